// File: rtl/taxi_fare.sv
// Incremental taxi fare meter: charges per-cycle deltas of the distance and
// wait-time counters against base fare, free distance and per-step rates.
module taxi_fare #(
  parameter int unsigned BASE_FARE  = 1300,
  parameter int unsigned FREE_DIST  = 3000,
  parameter int unsigned KM_UNITS   = 1000,
  parameter int unsigned KM_RATE    = 230,
  parameter int unsigned WAIT_UNITS = 30000,
  parameter int unsigned WAIT_RATE  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic [31:0] distance,
  input  logic [31:0] wait_time,
  output logic [31:0] money,
  output logic        charging,
  output logic        trip_done
);

  localparam int unsigned W  = 32;
  localparam int unsigned WX = W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   money_nxt;
  logic [W-1:0]   dist_prev, dist_prev_nxt;
  logic [W-1:0]   wait_prev, wait_prev_nxt;
  logic [W-1:0]   free_left, free_left_nxt;
  logic [W-1:0]   dist_rem, dist_rem_nxt;
  logic [W-1:0]   wait_rem, wait_rem_nxt;

  // Per-cycle delta datapath (modular subtraction absorbs counter wrap)
  logic [W-1:0]   dist_delta, free_used, dist_net, wait_delta;
  logic [WX-1:0]  dist_sum, wait_sum, money_sum;
  logic           dist_step, wait_step;

  always_comb begin
    dist_delta = distance - dist_prev;
    free_used  = (dist_delta < free_left) ? dist_delta : free_left;
    dist_net   = dist_delta - free_used;
    dist_sum   = WX'(dist_rem) + WX'(dist_net);
    dist_step  = (dist_sum >= WX'(KM_UNITS));
    wait_delta = wait_time - wait_prev;
    wait_sum   = WX'(wait_rem) + WX'(wait_delta);
    wait_step  = (wait_sum >= WX'(WAIT_UNITS));
    money_sum  = WX'(money)
               + (dist_step ? WX'(KM_RATE) : WX'(0))
               + (wait_step ? WX'(WAIT_RATE) : WX'(0));
  end

  // Next-state and register updates; precedence stop > start > pause
  always_comb begin
    logic load;
    state_nxt     = state;
    money_nxt     = money;
    dist_prev_nxt = dist_prev;
    wait_prev_nxt = wait_prev;
    free_left_nxt = free_left;
    dist_rem_nxt  = dist_rem;
    wait_rem_nxt  = wait_rem;
    load          = 1'b0;

    case (state)
      IDLE: begin
        money_nxt = '0;
        if (start) load = 1'b1;
      end
      RUN: begin
        if (stop) begin
          state_nxt = DONE;
        end else if (start) begin
          load = 1'b1;
        end else begin
          dist_prev_nxt = distance;
          wait_prev_nxt = wait_time;
          if (pause) begin
            state_nxt = HOLD;
          end else begin
            free_left_nxt = free_left - free_used;
            dist_rem_nxt  = dist_step ? W'(dist_sum - WX'(KM_UNITS)) : W'(dist_sum);
            wait_rem_nxt  = wait_step ? W'(wait_sum - WX'(WAIT_UNITS)) : W'(wait_sum);
            money_nxt     = money_sum[W] ? {W{1'b1}} : W'(money_sum);
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_nxt = DONE;
        end else if (start) begin
          load = 1'b1;
        end else begin
          dist_prev_nxt = distance;
          wait_prev_nxt = wait_time;
          if (!pause) state_nxt = RUN;
        end
      end
      DONE: begin
        if (start) load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      state_nxt     = RUN;
      money_nxt     = W'(BASE_FARE);
      dist_prev_nxt = distance;
      wait_prev_nxt = wait_time;
      free_left_nxt = W'(FREE_DIST);
      dist_rem_nxt  = '0;
      wait_rem_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      money     <= '0;
      dist_prev <= '0;
      wait_prev <= '0;
      free_left <= '0;
      dist_rem  <= '0;
      wait_rem  <= '0;
      charging  <= 1'b0;
      trip_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      money     <= money_nxt;
      dist_prev <= dist_prev_nxt;
      wait_prev <= wait_prev_nxt;
      free_left <= free_left_nxt;
      dist_rem  <= dist_rem_nxt;
      wait_rem  <= wait_rem_nxt;
      charging  <= (state_nxt == RUN);
      trip_done <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_taxi_fare.sv
// Directed self-checking bench for taxi_fare.
module tb_taxi_fare;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause;
  logic [31:0] distance, wait_time;
  logic [31:0] money;
  logic        charging, trip_done;

  int n_checks = 0;
  int n_fail   = 0;

  taxi_fare dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .distance(distance), .wait_time(wait_time),
    .money(money), .charging(charging), .trip_done(trip_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; pause = 0; distance = 0; wait_time = 0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if (money !== 32'd0) begin n_fail++; $display("FAIL reset_money: got %0d want 0", money); end
    n_checks++;
    if (charging !== 1'b0 || trip_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got charging=%b trip_done=%b want 0 0", charging, trip_done);
    end
    stop = 1'b1; step(); stop = 1'b0; step();
    n_checks++;
    if (money !== 32'd0 || trip_done !== 1'b0 || charging !== 1'b0) begin
      n_fail++; $display("FAIL idle_stop: got money=%0d charging=%b trip_done=%b want 0 0 0", money, charging, trip_done);
    end
  endtask

  task automatic test_base_free();
    distance = 0; wait_time = 0; start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (money !== 32'd1300 || charging !== 1'b1) begin
      n_fail++; $display("FAIL base_fare: got money=%0d charging=%b want 1300 1", money, charging);
    end
    for (int i = 1; i <= 300; i++) begin distance = 32'(i * 10); step(); end
    step();
    n_checks++;
    if (money !== 32'd1300) begin n_fail++; $display("FAIL free_dist_end: got %0d want 1300", money); end
  endtask

  task automatic test_metered();
    for (int i = 301; i <= 399; i++) begin distance = 32'(i * 10); step(); end
    n_checks++;
    if (money !== 32'd1300) begin n_fail++; $display("FAIL metered_3990: got %0d want 1300", money); end
    distance = 32'd4000; step();
    n_checks++;
    if (money !== 32'd1530) begin n_fail++; $display("FAIL metered_4000: got %0d want 1530", money); end
  endtask

  task automatic test_pause();
    pause = 1'b1; step();
    n_checks++;
    if (charging !== 1'b0 || money !== 32'd1530) begin
      n_fail++; $display("FAIL pause_enter: got charging=%b money=%0d want 0 1530", charging, money);
    end
    distance = 32'd5500; wait_time = 32'd40000; step(); step();
    n_checks++;
    if (money !== 32'd1530) begin n_fail++; $display("FAIL pause_hold: got %0d want 1530", money); end
    pause = 1'b0; step(); step();
    n_checks++;
    if (money !== 32'd1530 || charging !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume: got money=%0d charging=%b want 1530 1", money, charging);
    end
    for (int i = 551; i <= 649; i++) begin distance = 32'(i * 10); step(); end
    n_checks++;
    if (money !== 32'd1530) begin n_fail++; $display("FAIL resume_6490: got %0d want 1530", money); end
    distance = 32'd6500; step();
    n_checks++;
    if (money !== 32'd1760) begin n_fail++; $display("FAIL resume_6500: got %0d want 1760", money); end
  endtask

  task automatic test_wait();
    wait_time = 32'd70000; step();
    n_checks++;
    if (money !== 32'd1860) begin n_fail++; $display("FAIL wait_step1: got %0d want 1860", money); end
    wait_time = 32'd100000; step();
    n_checks++;
    if (money !== 32'd1960) begin n_fail++; $display("FAIL wait_step2: got %0d want 1960", money); end
    distance = 32'd7500; wait_time = 32'd130000; step();
    n_checks++;
    if (money !== 32'd2290) begin n_fail++; $display("FAIL both_charges: got %0d want 2290", money); end
  endtask

  task automatic test_wrap_burst();
    distance = 32'd0; start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (money !== 32'd1300) begin n_fail++; $display("FAIL restart_run: got %0d want 1300", money); end
    distance = 32'd3000; step();
    pause = 1'b1; step();
    distance = 32'hFFFF_FC18; step();
    pause = 1'b0; step();
    n_checks++;
    if (money !== 32'd1300) begin n_fail++; $display("FAIL wrap_setup: got %0d want 1300", money); end
    distance = 32'h0000_03E8; step();
    n_checks++;
    if (money !== 32'd1530) begin n_fail++; $display("FAIL wrap_burst1: got %0d want 1530", money); end
    step();
    n_checks++;
    if (money !== 32'd1760) begin n_fail++; $display("FAIL wrap_burst2: got %0d want 1760", money); end
    step();
    n_checks++;
    if (money !== 32'd1760) begin n_fail++; $display("FAIL wrap_drained: got %0d want 1760", money); end
  endtask

  task automatic test_stop_restart_reset();
    stop = 1'b1; step(); stop = 1'b0;
    n_checks++;
    if (trip_done !== 1'b1 || charging !== 1'b0 || money !== 32'd1760) begin
      n_fail++; $display("FAIL stop: got trip_done=%b charging=%b money=%0d want 1 0 1760", trip_done, charging, money);
    end
    distance = 32'd5000; wait_time = 32'd500000; step(); step();
    n_checks++;
    if (money !== 32'd1760) begin n_fail++; $display("FAIL done_hold: got %0d want 1760", money); end
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (money !== 32'd1300 || charging !== 1'b1 || trip_done !== 1'b0) begin
      n_fail++; $display("FAIL done_restart: got money=%0d charging=%b trip_done=%b want 1300 1 0", money, charging, trip_done);
    end
    distance = 32'd6000; step();
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if (money !== 32'd0 || charging !== 1'b0 || trip_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got money=%0d charging=%b trip_done=%b want 0 0 0", money, charging, trip_done);
    end
  endtask

  task automatic test_coincide();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_checks++;
    if (money !== 32'd1300 || charging !== 1'b1) begin
      n_fail++; $display("FAIL idle_start_stop: got money=%0d charging=%b want 1300 1", money, charging);
    end
    distance = 32'd20000; start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_checks++;
    if (money !== 32'd1300 || trip_done !== 1'b1) begin
      n_fail++; $display("FAIL run_start_stop: got money=%0d trip_done=%b want 1300 1", money, trip_done);
    end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_checks++;
    if (charging !== 1'b1 || trip_done !== 1'b0 || money !== 32'd1300) begin
      n_fail++; $display("FAIL done_start_stop: got charging=%b trip_done=%b money=%0d want 1 0 1300", charging, trip_done, money);
    end
  endtask

  initial begin
    test_reset();
    test_base_free();
    test_metered();
    test_pause();
    test_wait();
    test_wrap_burst();
    test_stop_restart_reset();
    test_coincide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
